toaplan2_cen_bank: RTL and testbench

TOAPLAN2_CEN_BANK -- requirements
Module: toaplan2_cen_bank

---
 rtl/toaplan2_cen_pkg.sv | 20 ++
 rtl/toaplan2_cen_chan.sv | 101 ++++++++++
 rtl/toaplan2_cen_bank.sv | 67 ++++++
 tb/tb_toaplan2_cen_bank.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/toaplan2_cen_pkg.sv
// Shared definitions for the Toaplan2 clock-enable bank: default sizes,
// the per-channel ratio record and the ratio-validity rule.
package toaplan2_cen_pkg;

  localparam int CEN_W_DEF   = 10;
  localparam int CEN_NCH_DEF = 4;

  // One channel's fractional divider setting: CEN rate = n/m of the clock.
  typedef struct packed {
    logic [CEN_W_DEF-1:0] n;
    logic [CEN_W_DEF-1:0] m;
  } cen_cfg_t;

  // A ratio is usable only if both terms are non-zero and n <= m/2, which
  // keeps the half-phase pulse and the full-phase pulse on separate cycles.
  function automatic logic ratio_ok(input logic [31:0] n, input logic [31:0] m);
    return (m != 32'd0) && (n != 32'd0) && (n <= (m >> 1));
  endfunction

endpackage

// File: rtl/toaplan2_cen_chan.sv
// One fractional clock-enable channel: an accumulator adds N per clock and
// wraps at M, giving CEN at exactly N/M of the clock and CENB at the half
// phase. Optional freeze input exists only when TOAPLAN2_CEN_PAUSE_EN is
// defined.
module toaplan2_cen_chan
  import toaplan2_cen_pkg::*;
#(
  parameter int           W     = CEN_W_DEF,
  parameter logic [W-1:0] DEF_N = W'(9),
  parameter logic [W-1:0] DEF_M = W'(320)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] cfg_n,
  input  logic [W-1:0] cfg_m,
`ifdef TOAPLAN2_CEN_PAUSE_EN
  input  logic         pause,
`endif
  output logic         cen,
  output logic         cenb,
  output logic         err
);

  localparam logic DEF_ERR = !ratio_ok(32'(DEF_N), 32'(DEF_M));

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] n_q, n_d;
  logic [W-1:0] m_q, m_d;
  logic         cen_q, cen_d;
  logic         cenb_q, cenb_d;
  logic         err_q, err_d;

  logic [W:0]   sum_s;
  logic [W:0]   m_ext_s;
  logic [W-1:0] half_s;
  logic         valid_s;

  assign sum_s   = {1'b0, acc_q} + {1'b0, n_q};
  assign m_ext_s = {1'b0, m_q};
  assign half_s  = m_q >> 1;
  assign valid_s = ratio_ok(32'(n_q), 32'(m_q));

  // Next accumulator, ratio and pulse values; a clear (ratio write or SYNC)
  // restarts the phase and swallows this cycle's pulses.
  always_comb begin
    n_d    = n_q;
    m_d    = m_q;
    acc_d  = acc_q;
    cen_d  = 1'b0;
    cenb_d = 1'b0;
    if (clr) begin
      if (load) begin
        n_d = cfg_n;
        m_d = cfg_m;
      end else begin
        n_d = n_q;
      end
      acc_d = {W{1'b0}};
    end else if (!valid_s) begin
      acc_d = {W{1'b0}};
`ifdef TOAPLAN2_CEN_PAUSE_EN
    end else if (pause) begin
      acc_d = acc_q;
`endif
    end else if (sum_s >= m_ext_s) begin
      acc_d = W'(sum_s - m_ext_s);
      cen_d = 1'b1;
    end else begin
      acc_d  = sum_s[W-1:0];
      cenb_d = (acc_q < half_s) && (sum_s >= {1'b0, half_s});
    end
    err_d = !ratio_ok(32'(n_d), 32'(m_d));
  end

  // Channel state registers; reset reloads the build-time ratio and drops
  // any phase in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q    <= DEF_N;
      m_q    <= DEF_M;
      acc_q  <= {W{1'b0}};
      cen_q  <= 1'b0;
      cenb_q <= 1'b0;
      err_q  <= DEF_ERR;
    end else begin
      n_q    <= n_d;
      m_q    <= m_d;
      acc_q  <= acc_d;
      cen_q  <= cen_d;
      cenb_q <= cenb_d;
      err_q  <= err_d;
    end
  end

  assign cen  = cen_q;
  assign cenb = cenb_q;
  assign err  = err_q;

endmodule

// File: rtl/toaplan2_cen_bank.sv
// Bank of NCH fractional clock-enable generators sharing one clock.
// Per-channel ratios load through CFG_*; SYNC restarts every phase.
// Define TOAPLAN2_CEN_PAUSE_EN to let PAUSE freeze channels in PAUSE_MASK;
// otherwise PAUSE is accepted and ignored.
module toaplan2_cen_bank
  import toaplan2_cen_pkg::*;
#(
  parameter int               NCH        = CEN_NCH_DEF,
  parameter int               W          = CEN_W_DEF,
  parameter logic [NCH*W-1:0] DEF_N      = {NCH{W'(9)}},
  parameter logic [NCH*W-1:0] DEF_M      = {NCH{W'(320)}},
  parameter logic [NCH-1:0]   PAUSE_MASK = {NCH{1'b0}},
  localparam int              CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           CFG_WE,
  input  logic [CHW-1:0] CFG_CH,
  input  logic [W-1:0]   CFG_N,
  input  logic [W-1:0]   CFG_M,
  input  logic           SYNC,
  input  logic           PAUSE,
  output logic [NCH-1:0] CEN,
  output logic [NCH-1:0] CENB,
  output logic [NCH-1:0] ERR
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic hit_s;
    logic clr_s;

    // Out-of-range channel numbers never match, so such writes are dropped.
    assign hit_s = CFG_WE && (32'(CFG_CH) == i);
    assign clr_s = SYNC || hit_s;

`ifdef TOAPLAN2_CEN_PAUSE_EN
    logic pause_s;
    assign pause_s = PAUSE && PAUSE_MASK[i];
`endif

    toaplan2_cen_chan #(
      .W     (W),
      .DEF_N (DEF_N[i*W +: W]),
      .DEF_M (DEF_M[i*W +: W])
    ) u_chan (
      .clk   (CLK),
      .rst_n (RESET_N),
      .clr   (clr_s),
      .load  (hit_s),
      .cfg_n (CFG_N),
      .cfg_m (CFG_M),
`ifdef TOAPLAN2_CEN_PAUSE_EN
      .pause (pause_s),
`endif
      .cen   (CEN[i]),
      .cenb  (CENB[i]),
      .err   (ERR[i])
    );
  end

`ifndef TOAPLAN2_CEN_PAUSE_EN
  // PAUSE has no function in this build; tie it off without any logic.
  logic unused_pause_s;
  assign unused_pause_s = PAUSE ^ (|PAUSE_MASK);
`endif

endmodule

// File: tb/tb_toaplan2_cen_bank.sv
// Scoreboard bench for toaplan2_cen_bank: stimulus pushes expected pulse
// edges and ERR levels into queues, a negedge monitor pops and compares.
module tb_toaplan2_cen_bank;
  import toaplan2_cen_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 10;
`ifdef TOAPLAN2_CEN_PAUSE_EN
  localparam int PSHIFT = 10;
`else
  localparam int PSHIFT = 0;
`endif

  logic           clk = 1'b0;
  logic           RESET_N, CFG_WE, SYNC, PAUSE;
  logic [1:0]     CFG_CH;
  logic [W-1:0]   CFG_N, CFG_M;
  logic [NCH-1:0] CEN, CENB, ERR;

  always #5 clk = ~clk;

  toaplan2_cen_bank #(.NCH(NCH), .W(W), .PAUSE_MASK(4'b0010)) dut (
    .CLK(clk), .RESET_N(RESET_N), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
    .CFG_N(CFG_N), .CFG_M(CFG_M), .SYNC(SYNC), .PAUSE(PAUSE),
    .CEN(CEN), .CENB(CENB), .ERR(ERR)
  );

  typedef struct { int cyc; logic [NCH-1:0] v; } err_ev_t;

  int      edge_n = 0;
  int      total  = 0;
  int      bad    = 0;
  int      cen_exp[NCH][$];
  int      cenb_exp[NCH][$];
  err_ev_t err_exp[$];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_err(input logic [NCH-1:0] v);
    err_ev_t e;
    e.cyc = edge_n;
    e.v   = v;
    err_exp.push_back(e);
  endtask

  // Closed-form pulse edges after a clear at 'base':
  // k-th CEN at ceil(k*M/N), k-th CENB at ceil((M/2 + (k-1)*M)/N).
  task automatic push_train(input int ch, input int base, input int n, input int m, input int last);
    int half;
    int t;
    half = m / 2;
    for (int k = 1; k < 1000; k++) begin
      t = base + (k * m + n - 1) / n;
      if (t > last) break;
      cen_exp[ch].push_back(t);
    end
    for (int k = 1; k < 1000; k++) begin
      t = base + (half + (k - 1) * m + n - 1) / n;
      if (t > last) break;
      cenb_exp[ch].push_back(t);
    end
  endtask

  task automatic cfg(input int ch, input int n, input int m);
    cen_cfg_t c;
    c.n    = 10'(n);
    c.m    = 10'(m);
    CFG_WE = 1'b1;
    CFG_CH = 2'(ch);
    CFG_N  = c.n;
    CFG_M  = c.m;
    tick();
    CFG_WE = 1'b0;
  endtask

  // Monitor: every pulse must match the head of its channel's queue.
  always @(negedge clk) begin
    err_ev_t e;
    for (int ch = 0; ch < NCH; ch++) begin
      while (cen_exp[ch].size() > 0 && cen_exp[ch][0] < edge_n) begin
        total++; bad++;
        $display("FAIL cen_missing ch=%0d actual=none required_edge=%0d", ch, cen_exp[ch][0]);
        void'(cen_exp[ch].pop_front());
      end
      if (CEN[ch] === 1'b1) begin
        total++;
        if (cen_exp[ch].size() > 0 && cen_exp[ch][0] == edge_n) begin
          void'(cen_exp[ch].pop_front());
        end else begin
          bad++;
          $display("FAIL cen_pulse ch=%0d actual_edge=%0d required_edge=%0d", ch, edge_n,
                   (cen_exp[ch].size() > 0) ? cen_exp[ch][0] : -1);
        end
      end
      while (cenb_exp[ch].size() > 0 && cenb_exp[ch][0] < edge_n) begin
        total++; bad++;
        $display("FAIL cenb_missing ch=%0d actual=none required_edge=%0d", ch, cenb_exp[ch][0]);
        void'(cenb_exp[ch].pop_front());
      end
      if (CENB[ch] === 1'b1) begin
        total++;
        if (cenb_exp[ch].size() > 0 && cenb_exp[ch][0] == edge_n) begin
          void'(cenb_exp[ch].pop_front());
        end else begin
          bad++;
          $display("FAIL cenb_pulse ch=%0d actual_edge=%0d required_edge=%0d", ch, edge_n,
                   (cenb_exp[ch].size() > 0) ? cenb_exp[ch][0] : -1);
        end
      end
    end
    if ((|(CEN & CENB)) === 1'b1) begin
      total++; bad++;
      $display("FAIL overlap edge=%0d actual_cen=%b actual_cenb=%b required_and=0000", edge_n, CEN, CENB);
    end
    while (err_exp.size() > 0 && err_exp[0].cyc <= edge_n) begin
      e = err_exp.pop_front();
      total++;
      if (e.cyc != edge_n || ERR !== e.v) begin
        bad++;
        $display("FAIL err edge=%0d actual=%b required=%b", edge_n, ERR, e.v);
      end
    end
  end

  int cen_tab[9]  = '{36, 72, 107, 143, 178, 214, 249, 285, 320};
  int cenb_tab[9] = '{18, 54, 89, 125, 160, 196, 232, 267, 303};

  initial begin
    int base, a, s, r, x;
    RESET_N = 1'b0; CFG_WE = 1'b0; CFG_CH = 2'd0; CFG_N = 10'd0; CFG_M = 10'd0;
    SYNC = 1'b0; PAUSE = 1'b0;

    // Reset: defaults valid, no pulses
    repeat (3) begin
      tick();
      push_err(4'b0000);
    end
    RESET_N = 1'b1;
    base = edge_n;
    // Default 9/320 on every channel, one full period (hand table)
    for (int ch = 0; ch < NCH; ch++) begin
      for (int k = 0; k < 9; k++) begin
        cen_exp[ch].push_back(base + cen_tab[k]);
        cenb_exp[ch].push_back(base + cenb_tab[k]);
      end
    end
    repeat (320) tick();

    // Invalid ratios silence channels; 1/2 alternates on channel 0
    cfg(1, 0, 320);   push_err(4'b0010);
    cfg(2, 0, 320);   push_err(4'b0110);
    cfg(3, 200, 320); push_err(4'b1110);
    cfg(0, 1, 2);     push_err(4'b1110);
    base = edge_n;
    push_train(0, base, 1, 2, base + 20);
    repeat (20) tick();
    cfg(0, 0, 2);     push_err(4'b1111);
    // Valid ratio clears ERR; first CEN 36 edges later
    cfg(3, 9, 320);   push_err(4'b0111);
    base = edge_n;
    push_train(3, base, 9, 320, base + 40);
    repeat (40) tick();

    // Distinct ratios, then SYNC mid-period
    cfg(0, 3, 10);    push_err(4'b0110);
    a = edge_n;
    push_train(0, a, 3, 10, a + 2);
    cfg(1, 1, 7);     push_err(4'b0100);
    cfg(2, 5, 16);    push_err(4'b0000);
    SYNC = 1'b1;
    tick();
    SYNC = 1'b0;
    s = edge_n;
    push_err(4'b0000);
    push_train(0, s, 3, 10, s + 40);
    push_train(1, s, 1, 7, s + 40);
    push_train(2, s, 5, 16, s + 40);
    push_train(3, s, 9, 320, s + 40);
    repeat (40) tick();

    // Reset coincident with a write: write lost, defaults back
    RESET_N = 1'b0; CFG_WE = 1'b1; CFG_CH = 2'd0; CFG_N = 10'd1; CFG_M = 10'd2;
    tick();
    RESET_N = 1'b1; CFG_WE = 1'b0;
    r = edge_n;
    push_err(4'b0000);
    push_train(0, r, 9, 320, r + 40);
    push_train(1, r + PSHIFT, 9, 320, r + 40);
    push_train(2, r, 9, 320, r + 40);
    push_train(3, r, 9, 320, r + 40);
    // PAUSE for 10 edges mid-period (affects channel 1 only when enabled)
    for (int t = 1; t <= 40; t++) begin
      PAUSE = (t >= 5 && t <= 14);
      tick();
    end
    PAUSE = 1'b0;

    // SYNC together with a write: new ratio loads, all phases restart
    SYNC = 1'b1;
    cfg(1, 3, 10);
    SYNC = 1'b0;
    x = edge_n;
    push_err(4'b0000);
    push_train(0, x, 9, 320, x + 20);
    push_train(1, x, 3, 10, x + 20);
    push_train(2, x, 9, 320, x + 20);
    push_train(3, x, 9, 320, x + 20);
    repeat (20) tick();

    @(negedge clk);
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      if (cen_exp[ch].size() != 0 || cenb_exp[ch].size() != 0) begin
        total++; bad++;
        $display("FAIL leftover ch=%0d actual_pending=%0d required_pending=0", ch,
                 cen_exp[ch].size() + cenb_exp[ch].size());
      end
    end
    if (err_exp.size() != 0) begin
      total++; bad++;
      $display("FAIL err_leftover actual_pending=%0d required_pending=0", err_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
